// File: rtl/fetch_pkg.sv
// Shared widths, the fetch buffer entry type and the fetch sequencer view.
// The sequencer state is derived from buffer occupancy; it is never registered.
package fetch_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FILL,
    SEQ_STREAM,
    SEQ_FULL
  } seq_state_t;

  // STREAM and FULL both mean buffered + in-flight already claims both slots.
  function automatic seq_state_t seq_state(input logic [1:0] count, input logic inflight);
    if (count == 2'd2)              return SEQ_FULL;
    if (count == 2'd1 && inflight)  return SEQ_STREAM;
    if (count == 2'd0 && !inflight) return SEQ_IDLE;
    return SEQ_FILL;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order buffer of fetched {instr, pc}; slot0 is always the head,
// so consumers see registers directly with no read-pointer mux.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  logic [1:0]   count_q, count_d;
  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_entry_i;
          else                 slot1_d = push_entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = push_entry_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are reset too because they drive the consumer-facing outputs directly.
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot0_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues ROM reads, tracks the one read in flight and
// hands {instr, pc} to decode through a 2-entry buffer with branch redirect.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic                   pop, push, issue;
  logic [1:0]             count;
  fetch_pkg::fetch_entry_t push_entry, head;
  fetch_pkg::seq_state_t   seq;

  always_comb begin
    pop              = out_valid & out_ready;
    push             = inflight_q & ~branch_valid;
    push_entry.instr = imem_q;
    push_entry.pc    = inflight_pc_q;
    seq              = fetch_pkg::seq_state(count, inflight_q);
    // Issue only if the new read is guaranteed a slot when it lands next cycle.
    issue = en & ~branch_valid &
            (pop | ~((seq == fetch_pkg::SEQ_STREAM) | (seq == fetch_pkg::SEQ_FULL)));

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (branch_valid) begin
      pc_d = branch_target;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buffer u_buffer (
    .clk          (clk),
    .rst_n        (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (branch_valid),
    .count_o      (count),
    .head_o       (head)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a synchronous ROM model plus a queue-based
// reference of the fetch rules, with directed scenarios and a random soak.
module tb_instruction_fetch;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam logic [AW-1:0] RST_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          branch_valid = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_q = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] rom_base = 32'hA000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t m_fifo[$];
  int   m_pc;
  bit   m_inflight;
  int   m_inflight_pc;

  instruction_fetch #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_q        (imem_q),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_q <= rom_base + 32'(imem_addr);

  function automatic logic [31:0] rom_word(input int a);
    return rom_base + 32'(a);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_pc          = int'(RST_PC);
    m_inflight    = 1'b0;
    m_inflight_pc = 0;
  endtask

  function automatic void expect_now(output bit v, output ent_t e, output logic [15:0] a);
    v = (m_fifo.size() > 0);
    e = '{32'h0, 16'h0};
    if (v) e = m_fifo[0];
    a = 16'(m_pc);
  endfunction

  // Advance the reference across the next rising edge using the current inputs.
  task automatic tick();
    bit pop, issue;
    int occ;
    pop = (m_fifo.size() > 0) && out_ready;
    if (branch_valid) begin
      m_pc       = int'(branch_target);
      m_inflight = 1'b0;
      m_fifo.delete();
    end else begin
      occ   = m_fifo.size() + int'(m_inflight) - int'(pop);
      issue = en && (occ < 2);
      if (pop) void'(m_fifo.pop_front());
      if (m_inflight) m_fifo.push_back('{rom_word(m_inflight_pc), 16'(m_inflight_pc)});
      if (issue) begin
        m_inflight_pc = m_pc;
        m_pc          = (m_pc + 1) % 65536;
      end
      m_inflight = issue;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset(input logic [31:0] base);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; out_ready = 1'b0; branch_valid = 1'b0;
    rom_base = base;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    checks += 4;
    if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RST_PC); end
    if (out_pc !== 16'h0)     begin failures++; $display("FAIL reset_pc got=%h want=0000", out_pc); end
    if (out_instr !== 32'h0)  begin failures++; $display("FAIL reset_instr got=%h want=00000000", out_instr); end
  endtask

  task automatic test_first_fetch();
    bit ev; ent_t e; logic [15:0] ea;
    apply_reset(32'hA000_0000);
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_now(ev, e, ea);
      checks++;
      if (out_valid !== ev || imem_addr !== ea || (ev && (out_pc !== e.pc || out_instr !== e.instr))) begin
        failures++;
        $display("FAIL first_model cyc=%0d valid=%b/%b pc=%h/%h instr=%h/%h addr=%h/%h", cyc, out_valid, ev, out_pc, e.pc, out_instr, e.instr, imem_addr, ea);
      end
      if (i < 2) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL first_bubble cyc=%0d valid got=%b want=0", i, out_valid); end
      end else if (i <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'(i - 2) || out_instr !== 32'hA000_0000 + 32'(i - 2)) begin
          failures++;
          $display("FAIL first_word cyc=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, out_valid, out_pc, out_instr, 16'(i - 2), 32'hA000_0000 + 32'(i - 2));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ev; ent_t e; logic [15:0] ea;
    logic [15:0] next_acc;
    apply_reset(32'hA000_0000);
    en = 1'b1; next_acc = 16'h0;
    for (int i = 0; i < 24; i++) begin
      out_ready = !(i >= 3 && i < 9);
      expect_now(ev, e, ea);
      checks++;
      if (out_valid !== ev || imem_addr !== ea || (ev && (out_pc !== e.pc || out_instr !== e.instr))) begin
        failures++;
        $display("FAIL bp_model cyc=%0d valid=%b/%b pc=%h/%h instr=%h/%h addr=%h/%h", cyc, out_valid, ev, out_pc, e.pc, out_instr, e.instr, imem_addr, ea);
      end
      if (i >= 3 && i < 9) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h1 || out_instr !== 32'hA000_0001) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got v=%b pc=%h instr=%h want v=1 pc=0001 instr=a0000001", i, out_valid, out_pc, out_instr);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_pc !== next_acc) begin failures++; $display("FAIL bp_order cyc=%0d pc got=%h want=%h", i, out_pc, next_acc); end
        next_acc++;
      end
      tick();
    end
    checks++;
    if (next_acc !== 16'd16) begin failures++; $display("FAIL bp_throughput transfers got=%0d want=16", next_acc); end
  endtask

  task automatic test_branch();
    bit ev; ent_t e; logic [15:0] ea;
    logic [15:0] next_acc;
    apply_reset(32'hA000_0000);
    en = 1'b1; next_acc = 16'h0040;
    for (int i = 0; i < 16; i++) begin
      out_ready     = (i < 3) || (i >= 5);
      branch_valid  = (i == 5);
      branch_target = 16'h0040;
      expect_now(ev, e, ea);
      checks++;
      if (out_valid !== ev || imem_addr !== ea || (ev && (out_pc !== e.pc || out_instr !== e.instr))) begin
        failures++;
        $display("FAIL br_model cyc=%0d valid=%b/%b pc=%h/%h instr=%h/%h addr=%h/%h", cyc, out_valid, ev, out_pc, e.pc, out_instr, e.instr, imem_addr, ea);
      end
      if (i == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h1) begin failures++; $display("FAIL br_full cyc=%0d got v=%b pc=%h want v=1 pc=0001", i, out_valid, out_pc); end
      end
      if (i == 6) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL br_flush cyc=%0d valid got=%b want=0", i, out_valid); end
      end
      if (i > 5 && out_valid === 1'b1) begin
        checks++;
        if (out_pc !== next_acc) begin failures++; $display("FAIL br_order cyc=%0d pc got=%h want=%h", i, out_pc, next_acc); end
        next_acc++;
      end
      tick();
    end
    branch_valid = 1'b0;
    checks++;
    if (next_acc < 16'h0043) begin failures++; $display("FAIL br_resume next pc got=%h want>=0043", next_acc); end
  endtask

  task automatic test_enable();
    bit ev; ent_t e; logic [15:0] ea;
    logic [15:0] next_acc;
    bit saw_gap;
    apply_reset(32'hA000_0000);
    out_ready = 1'b1; next_acc = 16'h0; saw_gap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en = !(i >= 6 && i < 9);
      expect_now(ev, e, ea);
      checks++;
      if (out_valid !== ev || imem_addr !== ea || (ev && (out_pc !== e.pc || out_instr !== e.instr))) begin
        failures++;
        $display("FAIL en_model cyc=%0d valid=%b/%b pc=%h/%h instr=%h/%h addr=%h/%h", cyc, out_valid, ev, out_pc, e.pc, out_instr, e.instr, imem_addr, ea);
      end
      if (i >= 6 && i <= 10 && out_valid === 1'b0) saw_gap = 1'b1;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_pc !== next_acc) begin failures++; $display("FAIL en_order cyc=%0d pc got=%h want=%h", i, out_pc, next_acc); end
        next_acc++;
      end
      tick();
    end
    en = 1'b1;
    checks++;
    if (!saw_gap) begin failures++; $display("FAIL en_stall valid never dropped got=1 want=0"); end
  endtask

  task automatic test_wrap();
    bit ev; ent_t e; logic [15:0] ea;
    logic [15:0] next_acc;
    apply_reset(32'h5A5A_0000);
    en = 1'b1; out_ready = 1'b1; next_acc = 16'hFFFE;
    for (int i = 0; i < 13; i++) begin
      branch_valid  = (i == 4);
      branch_target = 16'hFFFE;
      expect_now(ev, e, ea);
      checks++;
      if (out_valid !== ev || imem_addr !== ea || (ev && (out_pc !== e.pc || out_instr !== e.instr))) begin
        failures++;
        $display("FAIL wrap_model cyc=%0d valid=%b/%b pc=%h/%h instr=%h/%h addr=%h/%h", cyc, out_valid, ev, out_pc, e.pc, out_instr, e.instr, imem_addr, ea);
      end
      if (i > 4 && out_valid === 1'b1) begin
        checks++;
        if (out_pc !== next_acc) begin failures++; $display("FAIL wrap_order cyc=%0d pc got=%h want=%h", i, out_pc, next_acc); end
        next_acc++;
      end
      tick();
    end
    branch_valid = 1'b0;
    checks++;
    if (next_acc !== 16'h0004) begin failures++; $display("FAIL wrap_count next pc got=%h want=0004", next_acc); end
  endtask

  task automatic test_async_reset();
    bit ev; ent_t e; logic [15:0] ea;
    apply_reset(32'hA000_0000);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      out_ready = (i < 3);
      expect_now(ev, e, ea);
      checks++;
      if (out_valid !== ev || imem_addr !== ea || (ev && (out_pc !== e.pc || out_instr !== e.instr))) begin
        failures++;
        $display("FAIL ar_model cyc=%0d valid=%b/%b pc=%h/%h instr=%h/%h addr=%h/%h", cyc, out_valid, ev, out_pc, e.pc, out_instr, e.instr, imem_addr, ea);
      end
      tick();
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks += 3;
    if (out_valid !== 1'b0)   begin failures++; $display("FAIL ar_valid got=%b want=0", out_valid); end
    if (imem_addr !== RST_PC) begin failures++; $display("FAIL ar_addr got=%h want=%h", imem_addr, RST_PC); end
    if (out_pc !== 16'h0 || out_instr !== 32'h0) begin failures++; $display("FAIL ar_head got pc=%h instr=%h want 0000/00000000", out_pc, out_instr); end
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2 && i <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'(i - 2) || out_instr !== 32'hA000_0000 + 32'(i - 2)) begin
          failures++;
          $display("FAIL ar_refetch cyc=%0d got v=%b pc=%h instr=%h want v=1 pc=%h", i, out_valid, out_pc, out_instr, 16'(i - 2));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit ev; ent_t e; logic [15:0] ea;
    int bad = 0;
    apply_reset($urandom);
    for (int i = 0; i < 3000; i++) begin
      en            = ($urandom_range(0, 9) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      branch_valid  = ($urandom_range(0, 29) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      expect_now(ev, e, ea);
      checks++;
      if (out_valid !== ev || imem_addr !== ea || (ev && (out_pc !== e.pc || out_instr !== e.instr))) begin
        failures++;
        if (bad < 10) $display("FAIL rand_model cyc=%0d valid=%b/%b pc=%h/%h instr=%h/%h addr=%h/%h", cyc, out_valid, ev, out_pc, e.pc, out_instr, e.instr, imem_addr, ea);
        bad++;
      end
      tick();
    end
    branch_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_branch();
    test_enable();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
